// File: rtl/ppu_pkg.sv
// Types and sizes shared by the partial-sum accumulator and the post-processing unit.
package ppu_pkg;

    localparam int unsigned LANES  = 16;
    localparam int unsigned ROWS   = 16;
    localparam int unsigned PSUM_W = 20;
    localparam int unsigned ACC_W  = 24;
    localparam int unsigned ROW_W  = $clog2(ROWS);

    // Lane g occupies bits [g*W +: W] of the flattened row.
    typedef logic [LANES-1:0][PSUM_W-1:0] psum_row_t;
    typedef logic [LANES-1:0][ACC_W-1:0]  acc_row_t;

    typedef enum logic [1:0] {
        DRAIN_IDLE   = 2'd0,
        DRAIN_START  = 2'd1,
        DRAIN_STREAM = 2'd2
    } drain_state_e;

endpackage

// File: rtl/psum_sat_add.sv
// One lane: sign-extend a partial sum and either load it or add it to the
// accumulator with saturation; ovf flags a clamped result.
module psum_sat_add
    import ppu_pkg::*;
(
    input  logic [PSUM_W-1:0] psum,
    input  logic [ACC_W-1:0]  acc,
    input  logic              first,
    output logic [ACC_W-1:0]  sum,
    output logic              ovf
);

    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic signed [ACC_W:0] psum_wide;
    logic signed [ACC_W:0] acc_wide;
    logic signed [ACC_W:0] total;

    assign psum_wide = (ACC_W+1)'($signed(psum));
    assign acc_wide  = (ACC_W+1)'($signed(acc));
    assign total     = acc_wide + psum_wide;

    // Top two bits of the guard-extended sum disagree only on overflow.
    always_comb begin
        sum = psum_wide[ACC_W-1:0];
        ovf = 1'b0;
        if (!first) begin
            if (total[ACC_W] != total[ACC_W-1]) begin
                ovf = 1'b1;
                sum = total[ACC_W] ? ACC_MIN : ACC_MAX;
            end else begin
                sum = total[ACC_W-1:0];
            end
        end
    end

endmodule

// File: rtl/psum_accumulator.sv
// Ping-pong tile accumulator: rows from the PE array accumulate into one bank
// while the other completed bank drains to the post-processing unit.
module psum_accumulator
    import ppu_pkg::*;
(
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_psum_valid,
    output logic                      o_psum_ready,
    input  logic [LANES*PSUM_W-1:0]   i_psum_data,
    input  logic                      i_psum_first,
    input  logic                      i_psum_last,
    output logic                      o_ppu_start,
    output logic [LANES*ACC_W-1:0]    o_acc_data,
    input  logic                      i_clr_sat,
    output logic                      o_sat_sticky
);

    acc_row_t          bank [2][ROWS];
    acc_row_t          sum_row;
    acc_row_t          acc_q;
    psum_row_t         psum_row;
    logic [LANES-1:0]  ovf;
    logic [1:0]        full;
    logic              wr_bank;
    logic              rd_bank;
    logic [ROW_W-1:0]  wr_row;
    logic [ROW_W-1:0]  rd_row;
    drain_state_e      state;
    logic              fire;
    logic              tile_done;
    logic              drain_done;

    assign psum_row     = i_psum_data;
    assign o_acc_data   = acc_q;
    assign o_psum_ready = ~full[wr_bank];
    assign fire         = i_psum_valid & o_psum_ready;
    assign tile_done    = fire & i_psum_last & (wr_row == ROW_W'(ROWS - 1));
    assign drain_done   = (state == DRAIN_STREAM) && (rd_row == '0);

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        psum_sat_add u_add (
            .psum  (psum_row[g]),
            .acc   (bank[wr_bank][wr_row][g]),
            .first (i_psum_first),
            .sum   (sum_row[g]),
            .ovf   (ovf[g])
        );
    end

    // Tile storage; contents are don't-care until written, so no reset.
    always_ff @(posedge i_clk) begin
        if (fire) begin
            bank[wr_bank][wr_row] <= sum_row;
        end
    end

    // Fill pointer, bank ownership and saturation flag.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_row       <= '0;
            wr_bank      <= 1'b0;
            full         <= '0;
            o_sat_sticky <= 1'b0;
        end else begin
            if (fire) begin
                wr_row <= wr_row + ROW_W'(1);
            end
            if (tile_done) begin
                wr_bank <= ~wr_bank;
            end
            for (int b = 0; b < 2; b++) begin
                if (tile_done && (wr_bank == 1'(b))) begin
                    full[b] <= 1'b1;
                end else if (drain_done && (rd_bank == 1'(b))) begin
                    full[b] <= 1'b0;
                end
            end
            if (fire && (|ovf)) begin
                o_sat_sticky <= 1'b1;
            end else if (i_clr_sat) begin
                o_sat_sticky <= 1'b0;
            end
        end
    end

    // Drain: start pulse, then rows 0..ROWS-1 on consecutive cycles.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= DRAIN_IDLE;
            rd_bank     <= 1'b0;
            rd_row      <= '0;
            o_ppu_start <= 1'b0;
            acc_q       <= '0;
        end else begin
            o_ppu_start <= 1'b0;
            unique case (state)
                DRAIN_IDLE: begin
                    if (full[rd_bank]) begin
                        state       <= DRAIN_START;
                        o_ppu_start <= 1'b1;
                    end
                end
                DRAIN_START: begin
                    acc_q  <= bank[rd_bank][rd_row];
                    rd_row <= rd_row + ROW_W'(1);
                    state  <= DRAIN_STREAM;
                end
                DRAIN_STREAM: begin
                    if (rd_row == '0) begin
                        acc_q   <= '0;
                        rd_bank <= ~rd_bank;
                        state   <= DRAIN_IDLE;
                    end else begin
                        acc_q  <= bank[rd_bank][rd_row];
                        rd_row <= rd_row + ROW_W'(1);
                    end
                end
                default: state <= DRAIN_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_psum_accumulator.sv
// Scoreboard bench for psum_accumulator: directed tiles push expected rows,
// a negedge monitor checks every drained row and idle cycle.
module tb_psum_accumulator;
    import ppu_pkg::*;

    localparam int unsigned DW = LANES * ACC_W;

    logic      i_clk = 1'b0;
    logic      i_rst_n = 1'b0;
    logic      i_psum_valid = 1'b0;
    logic      o_psum_ready;
    psum_row_t i_psum_data = '0;
    logic      i_psum_first = 1'b0;
    logic      i_psum_last = 1'b0;
    logic      o_ppu_start;
    acc_row_t  o_acc_data;
    logic      i_clr_sat = 1'b0;
    logic      o_sat_sticky;

    int        errors = 0;
    int        checks = 0;
    int        cyc = 0;
    int        cnt = 0;
    int        stalls = 0;
    int        start_count = 0;
    acc_row_t  exp_q[$];
    int        start_q[$];

    psum_accumulator dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_psum_valid (i_psum_valid),
        .o_psum_ready (o_psum_ready),
        .i_psum_data  (i_psum_data),
        .i_psum_first (i_psum_first),
        .i_psum_last  (i_psum_last),
        .o_ppu_start  (o_ppu_start),
        .o_acc_data   (o_acc_data),
        .i_clr_sat    (i_clr_sat),
        .o_sat_sticky (o_sat_sticky)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc++;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic psum_row_t ramp_row(input int r);
        psum_row_t d;
        for (int g = 0; g < LANES; g++) d[g] = PSUM_W'(r * 16 + g);
        return d;
    endfunction

    function automatic psum_row_t const_row(input int v);
        psum_row_t d;
        for (int g = 0; g < LANES; g++) d[g] = PSUM_W'(v);
        return d;
    endfunction

    function automatic acc_row_t ramp_acc(input int r);
        acc_row_t d;
        for (int g = 0; g < LANES; g++) d[g] = ACC_W'(r * 16 + g);
        return d;
    endfunction

    function automatic acc_row_t const_acc(input int v);
        acc_row_t d;
        for (int g = 0; g < LANES; g++) d[g] = ACC_W'(v);
        return d;
    endfunction

    // Monitor: compares drained rows against the scoreboard, zeros elsewhere.
    always @(negedge i_clk) begin
        if (!i_rst_n) begin
            cnt = 0;
        end else begin
            if (cnt > 0) begin
                if (exp_q.size() == 0) chk("row_underflow", 1, 0);
                else chk("drain_row", o_acc_data, exp_q.pop_front());
                cnt--;
            end else begin
                chk("idle_zero", o_acc_data, 0);
            end
            if (o_ppu_start) begin
                chk("start_expected", DW'(exp_q.size() >= ROWS), 1);
                start_q.push_back(cyc);
                start_count++;
                cnt = ROWS;
            end
        end
    end

    task automatic align();
        @(posedge i_clk);
        #1;
    endtask

    // Called #1 after a posedge; returns #1 after the handshake edge.
    task automatic send_row(input psum_row_t d, input logic first, input logic last);
        int   n = 0;
        logic hs;
        i_psum_data  = d;
        i_psum_first = first;
        i_psum_last  = last;
        i_psum_valid = 1'b1;
        do begin
            @(negedge i_clk);
            hs = o_psum_ready;
            if (!hs) stalls++;
            @(posedge i_clk);
            #1;
            n++;
        end while (!hs && n < 200);
        if (!hs) chk("handshake_timeout", 0, 1);
        i_psum_valid = 1'b0;
    endtask

    task automatic send_pass(input bit ramp, input int v, input logic first, input logic last);
        for (int r = 0; r < ROWS; r++) send_row(ramp ? ramp_row(r) : const_row(v), first, last);
    endtask

    task automatic push_tile(input bit ramp, input int v);
        for (int r = 0; r < ROWS; r++) exp_q.push_back(ramp ? ramp_acc(r) : const_acc(v));
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || cnt != 0) && n < 200) begin
            @(negedge i_clk);
            n++;
        end
        chk("drain_complete", DW'(exp_q.size() == 0 && cnt == 0), 1);
        repeat (3) @(negedge i_clk);
        align();
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        int rise_cyc;
        int sc;

        repeat (3) @(posedge i_clk);
        #1 i_rst_n = 1'b1;
        @(negedge i_clk);
        chk("rst_start", o_ppu_start, 0);
        chk("rst_data", o_acc_data, 0);
        chk("rst_sticky", o_sat_sticky, 0);
        chk("rst_ready", o_psum_ready, 1);
        align();

        // Single ramp pass, start one edge after the final handshake edge.
        stalls = 0;
        push_tile(1'b1, 0);
        send_pass(1'b1, 0, 1'b1, 1'b1);
        chk("ramp_no_stall", stalls, 0);
        chk("ramp_start_lat0", o_ppu_start, 0);
        align();
        chk("ramp_start_lat1", o_ppu_start, 1);
        wait_drain();

        // Three passes of -5.
        push_tile(1'b0, -15);
        send_pass(1'b0, -5, 1'b1, 1'b0);
        send_pass(1'b0, -5, 1'b0, 1'b0);
        send_pass(1'b0, -5, 1'b0, 1'b1);
        wait_drain();

        // 16 passes of max reach 8388592 unclamped; the 17th clamps.
        push_tile(1'b0, 8388607);
        send_pass(1'b0, 524287, 1'b1, 1'b0);
        for (int p = 1; p < 16; p++) send_pass(1'b0, 524287, 1'b0, 1'b0);
        chk("sat_not_yet", o_sat_sticky, 0);
        send_pass(1'b0, 524287, 1'b0, 1'b1);
        chk("sat_set", o_sat_sticky, 1);
        wait_drain();
        chk("sat_held", o_sat_sticky, 1);
        i_clr_sat = 1'b1;
        align();
        i_clr_sat = 1'b0;
        chk("sat_cleared", o_sat_sticky, 0);

        // Negative: 16 passes land exactly on the minimum; the 17th clamps with clear held.
        push_tile(1'b0, -8388608);
        send_pass(1'b0, -524288, 1'b1, 1'b0);
        for (int p = 1; p < 16; p++) send_pass(1'b0, -524288, 1'b0, 1'b0);
        chk("min_no_sat", o_sat_sticky, 0);
        i_clr_sat = 1'b1;
        send_pass(1'b0, -524288, 1'b0, 1'b1);
        chk("set_beats_clr", o_sat_sticky, 1);
        i_clr_sat = 1'b0;
        wait_drain();

        // Back-to-back tiles: ready drops until the first drain frees its bank.
        start_q.delete();
        push_tile(1'b1, 0);
        push_tile(1'b0, 7);
        send_pass(1'b1, 0, 1'b1, 1'b1);
        send_pass(1'b0, 7, 1'b1, 1'b1);
        chk("bp_ready_low", o_psum_ready, 0);
        n = 0;
        do begin
            @(negedge i_clk);
            n++;
        end while (!o_psum_ready && n < 60);
        rise_cyc = cyc;
        chk("bp_ready_rise", o_psum_ready, 1);
        if (start_q.size() >= 1) chk("bp_rise_time", rise_cyc - start_q[0], 17);
        else chk("bp_first_start", 0, 1);
        align();
        wait_drain();
        chk("bp_two_starts", start_q.size(), 2);
        if (start_q.size() == 2) chk("bp_spacing", start_q[1] - start_q[0], 18);

        // Reset while row 7 is on the output.
        push_tile(1'b1, 0);
        send_pass(1'b1, 0, 1'b1, 1'b1);
        n = 0;
        do begin
            @(negedge i_clk);
            n++;
        end while (!o_ppu_start && n < 50);
        chk("rst_mid_start", o_ppu_start, 1);
        repeat (8) @(negedge i_clk);
        #2 i_rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("rst_mid_data", o_acc_data, 0);
        chk("rst_mid_start0", o_ppu_start, 0);
        chk("rst_mid_ready", o_psum_ready, 1);
        repeat (3) @(negedge i_clk);
        align();
        i_rst_n = 1'b1;
        sc = start_count;
        repeat (40) @(negedge i_clk);
        chk("rst_no_start", start_count - sc, 0);
        chk("rst_ready_after", o_psum_ready, 1);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
